// File: rtl/edid_ddc_responder_pkg.sv
// Shared constants and state encoding for the EDID DDC responder.
package edid_ddc_responder_pkg;

  // EDID data address (0xA0 write / 0xA1 read) and E-DDC segment pointer.
  localparam logic [6:0] EDID_DEV_ADDR = 7'h50;
  localparam logic [6:0] EDID_SEG_ADDR = 7'h30;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_OFF,
    ST_OFF_ACK,
    ST_WR_EXTRA,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } ddc_state_e;

endpackage

// File: rtl/edid_ddc_responder_if.sv
// DDC pin bundle: SCL/SDA as seen from the source, plus the open-drain SDA pull.
interface edid_ddc_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  // master: the video source side (drives the lines, sees our pull-down)
  modport master (output scl_in, output sda_in, input sda_oe);
  // slave: the responder
  modport slave (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/edid_ddc_responder_line_filter.sv
// Synchronizer, glitch filter and edge/START/STOP detector for the SCL/SDA pair.
// Both lines share an identical pipeline so their relative timing is preserved.
// FILT_LEN must be at least 2.
module ddc_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic gclk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl, scl_q, sda_q;

  // Two-flop sync, then a level change is accepted only once FILT_LEN samples agree.
  always_ff @(posedge gclk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl      <= 1'b1;
      sda      <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_raw};
      sda_sync <= {sda_sync[0], sda_raw};
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
      if (&scl_hist)       scl <= 1'b1;
      else if (~|scl_hist) scl <= 1'b0;
      if (&sda_hist)       sda <= 1'b1;
      else if (~|sda_hist) sda <= 1'b0;
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  // START/STOP need SCL high both before and after the SDA transition.
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/edid_ddc_responder.sv
// DDC slave serving the local EDID image at 0x50. Read-only: offset writes are
// accepted, further written bytes are NACKed. Offset persists across transactions.
module edid_ddc_responder
  import edid_ddc_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = EDID_DEV_ADDR,
  parameter int         FILT_LEN = 3
) (
  input  logic                       gclk,
  input  logic                       rst,
  edid_ddc_responder_if.slave        ddc,
  input  logic                       edid_valid,
  output logic [7:0]                 ram_addr,
  input  logic [7:0]                 ram_data,
  output logic                       busy,
  output logic                       byte_sent,
  output ddc_state_e                 dbg_state
);

  logic sda, scl_rise, scl_fall, start, stop;

  ddc_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .gclk     (gclk),
    .rst      (rst),
    .scl_raw  (ddc.scl_in),
    .sda_raw  (ddc.sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  ddc_state_e state, state_n;
  logic [7:0] rx, rx_n, tx, tx_n, offset, offset_n;
  logic [3:0] cnt, cnt_n;
  logic       rw, rw_n, oe, oe_n, busy_r, busy_n, sent, sent_n;
  logic       addr_match;

  assign addr_match = (rx[7:1] == DEV_ADDR) && (rx[7:1] != EDID_SEG_ADDR) && edid_valid;

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge gclk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rx     <= '0;
      tx     <= '0;
      offset <= '0;
      cnt    <= '0;
      rw     <= 1'b0;
      oe     <= 1'b0;
      busy_r <= 1'b0;
      sent   <= 1'b0;
    end else begin
      state  <= state_n;
      rx     <= rx_n;
      tx     <= tx_n;
      offset <= offset_n;
      cnt    <= cnt_n;
      rw     <= rw_n;
      oe     <= oe_n;
      busy_r <= busy_n;
      sent   <= sent_n;
    end
  end

  // Next-state logic: START/STOP win over bit processing; SDA moves only on scl_fall.
  always_comb begin
    state_n  = state;
    rx_n     = rx;
    cnt_n    = cnt;
    offset_n = offset;
    rw_n     = rw;
    oe_n     = oe;
    busy_n   = busy_r;
    sent_n   = 1'b0;
    // Outside a byte being shifted out, keep prefetching mem[offset].
    tx_n     = (state == ST_RD_BYTE) ? tx : ram_data;

    if (start) begin
      state_n = ST_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (stop) begin
      state_n = ST_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            rx_n  = {rx[6:0], sda};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (addr_match) begin
              state_n = ST_ADDR_ACK;
              oe_n    = 1'b1;
              busy_n  = 1'b1;
              rw_n    = rx[0];
            end else begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_n = ST_RD_BYTE;
              oe_n    = ~tx[7];
              tx_n    = {tx[6:0], 1'b0};
              cnt_n   = 4'd1;
            end else begin
              state_n = ST_WR_OFF;
              oe_n    = 1'b0;
              cnt_n   = '0;
            end
          end
        end
        ST_WR_OFF: begin
          if (scl_rise) begin
            rx_n  = {rx[6:0], sda};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            offset_n = rx;
            oe_n     = 1'b1;
            state_n  = ST_OFF_ACK;
          end
        end
        ST_OFF_ACK: begin
          if (scl_fall) begin
            oe_n    = 1'b0;
            state_n = ST_WR_EXTRA;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              state_n = ST_RD_ACK;
            end else begin
              oe_n  = ~tx[7];
              tx_n  = {tx[6:0], 1'b0};
              cnt_n = cnt + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          // cnt==9 marks "master ACKed, next byte starts on the coming fall".
          if (scl_rise) begin
            sent_n   = 1'b1;
            offset_n = offset + 8'd1;
            if (sda) state_n = ST_IGNORE;
            else     cnt_n   = 4'd9;
          end else if (scl_fall && cnt == 4'd9) begin
            oe_n    = ~tx[7];
            tx_n    = {tx[6:0], 1'b0};
            cnt_n   = 4'd1;
            state_n = ST_RD_BYTE;
          end
        end
        ST_WR_EXTRA, ST_IGNORE: oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign ddc.sda_oe = oe;
  assign ram_addr   = offset;
  assign busy       = busy_r;
  assign byte_sent  = sent;
  assign dbg_state  = state;

endmodule

// File: tb/tb_edid_ddc_responder.sv
// Bench for edid_ddc_responder: bit-level DDC master, EDID RAM holding i^0x5A,
// scoreboard of ACK bits and read bytes, plus direct checks on busy/byte_sent/reset.
module tb_edid_ddc_responder;
  import edid_ddc_responder_pkg::*;

  localparam int         Q        = 10;
  localparam logic [7:0] TAG_ACK  = 8'hAC;
  localparam logic [7:0] TAG_DATA = 8'hDA;

  logic       gclk, rst, edid_valid, busy, byte_sent;
  logic [7:0] ram_addr, ram_data;
  ddc_state_e dbg_state;
  logic       scl_m, sda_m;
  int         checks = 0, failures = 0, sent_cnt = 0, oe_cnt = 0, base;
  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];
  logic [15:0] m_act, m_exp;

  edid_ddc_responder_if bus();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  edid_ddc_responder #(.DEV_ADDR(7'h50), .FILT_LEN(3)) dut (
    .gclk       (gclk),
    .rst        (rst),
    .ddc        (bus.slave),
    .edid_valid (edid_valid),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .busy       (busy),
    .byte_sent  (byte_sent),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial begin
    gclk = 1'b0;
    forever #20 gclk = ~gclk;
  end

  // EDID RAM model: one-cycle read latency, mem[i] = i ^ 0x5A
  always @(posedge gclk) ram_data <= ram_addr ^ 8'h5A;

  always @(posedge gclk) begin
    if (byte_sent)  sent_cnt <= sent_cnt + 1;
    if (bus.sda_oe) oe_cnt   <= oe_cnt + 1;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge gclk);
      while (act_q.size() > 0) begin
        m_act = act_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got=%h want=none", m_act);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_act !== m_exp) begin
            failures++;
            $display("FAIL sb_%s got=%h want=%h", (m_exp[15:8] == TAG_ACK) ? "ack" : "data",
                     m_act, m_exp);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(negedge gclk);
  endtask

  task automatic clk_bit(input logic b, input logic glitch, output logic s);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    repeat (4) @(negedge gclk);
    if (glitch) begin
      sda_m = ~b;
      @(negedge gclk);
      sda_m = b;
    end
    repeat (6) @(negedge gclk);
    s = bus.sda_in;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic start_c();
    if (!scl_m) begin
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
    end
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic [7:0] gmask, input logic exp_nack);
    logic s;
    exp_q.push_back({TAG_ACK, 7'd0, exp_nack});
    for (int i = 7; i >= 0; i--) clk_bit(d[i], gmask[i], s);
    clk_bit(1'b1, 1'b0, s);
    act_q.push_back({TAG_ACK, 7'd0, s});
  endtask

  task automatic rd_byte(input logic [7:0] want, input logic mnack);
    logic s;
    logic [7:0] v;
    v = '0;
    exp_q.push_back({TAG_DATA, want});
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      v = {v[6:0], s};
    end
    clk_bit(mnack, 1'b0, s);
    act_q.push_back({TAG_DATA, v});
  endtask

  initial begin
    rst = 1'b1; edid_valid = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge gclk);
    chk("rst_sda_oe", 8'(bus.sda_oe), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_byte_sent", 8'(byte_sent), 8'd0);
    chk("rst_ram_addr", ram_addr, 8'h00);
    chk("rst_state", 8'(dbg_state), 8'(ST_IDLE));
    rst = 1'b0;
    repeat (5) @(negedge gclk);

    // offset 0, repeated START, sequential read of 4 bytes
    base = sent_cnt;
    start_c(); wr_byte(8'hA0, 8'h00, 1'b0); wr_byte(8'h00, 8'h00, 1'b0);
    start_c(); wr_byte(8'hA1, 8'h00, 1'b0);
    rd_byte(8'h5A, 1'b0); rd_byte(8'h5B, 1'b0); rd_byte(8'h58, 1'b0); rd_byte(8'h59, 1'b1);
    chk("t1_busy_before_stop", 8'(busy), 8'd1);
    stop_c();
    chk("t1_busy_after_stop", 8'(busy), 8'd0);
    chk("t1_byte_sent", 8'(sent_cnt - base), 8'd4);

    // offset wrap 0xFE -> 0xFF -> 0x00
    base = sent_cnt;
    start_c(); wr_byte(8'hA0, 8'h00, 1'b0); wr_byte(8'hFE, 8'h00, 1'b0);
    start_c(); wr_byte(8'hA1, 8'h00, 1'b0);
    rd_byte(8'hA4, 1'b0); rd_byte(8'hA5, 1'b0); rd_byte(8'h5A, 1'b1);
    stop_c();
    chk("t2_byte_sent", 8'(sent_cnt - base), 8'd3);

    // EDID not valid: address NACKed, SDA never pulled
    edid_valid = 1'b0;
    base = oe_cnt;
    start_c(); wr_byte(8'hA1, 8'h00, 1'b1); stop_c();
    chk("t3_oe_activity", 8'(oe_cnt - base), 8'd0);
    chk("t3_busy", 8'(busy), 8'd0);
    edid_valid = 1'b1;

    // foreign address: silence until STOP; then read continues at offset 0x01
    base = oe_cnt;
    start_c(); wr_byte(8'hA4, 8'h00, 1'b1); wr_byte(8'hFF, 8'h00, 1'b1); stop_c();
    chk("t4_oe_activity", 8'(oe_cnt - base), 8'd0);
    start_c(); wr_byte(8'hA1, 8'h00, 1'b0); rd_byte(8'h5B, 1'b1); stop_c();

    // segment pointer address is not answered
    start_c(); wr_byte(8'h60, 8'h00, 1'b1); stop_c();

    // extra write byte NACKed and discarded
    start_c(); wr_byte(8'hA0, 8'h00, 1'b0); wr_byte(8'h10, 8'h00, 1'b0);
    wr_byte(8'h77, 8'h00, 1'b1); stop_c();
    start_c(); wr_byte(8'hA1, 8'h00, 1'b0); rd_byte(8'h4A, 1'b1); stop_c();

    // glitches: idle SDA low pulse (false START), SDA high pulse mid-bit (false STOP)
    @(negedge gclk); sda_m = 1'b0;
    @(negedge gclk); sda_m = 1'b1;
    repeat (20) @(negedge gclk);
    chk("t6_idle_glitch_state", 8'(dbg_state), 8'(ST_IDLE));
    start_c(); wr_byte(8'hA0, 8'h00, 1'b0); wr_byte(8'h20, 8'h80, 1'b0);
    start_c(); wr_byte(8'hA1, 8'h00, 1'b0); rd_byte(8'h7A, 1'b1); stop_c();

    // reset while driving a 0 data bit (mem[0x21] = 0x7B)
    start_c(); wr_byte(8'hA1, 8'h00, 1'b0);
    repeat (3) @(negedge gclk);
    chk("t7_driving", 8'(bus.sda_oe), 8'd1);
    rst = 1'b1;
    @(negedge gclk);
    chk("t7_rst_sda_oe", 8'(bus.sda_oe), 8'd0);
    chk("t7_rst_busy", 8'(busy), 8'd0);
    chk("t7_rst_state", 8'(dbg_state), 8'(ST_IDLE));
    chk("t7_rst_ram_addr", ram_addr, 8'h00);
    rst = 1'b0;
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (20) @(negedge gclk);

    // final report
    repeat (5) @(negedge gclk);
    chk("sb_leftover_expected", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edid_ddc_responder.md
Name: edid_ddc_responder

Overview:
- DDC (I2C) slave that serves the locally held EDID image to the video source (PC) on its DDC lines at device address 0x50 (0xA0 write, 0xA1 read).
- Upstream counterpart of the monitor-side EDID read: once the EDID buffer is filled and flagged valid, this block answers the source's EDID reads byte by byte from the EDID RAM.
- Sits beside the system controller; the controller raises source HPD only after EDID is valid.

Parameters:
- DEV_ADDR, 7'h50, 7-bit slave address answered.
- FILT_LEN, 3, consecutive identical gclk samples needed to accept an SCL/SDA level change (glitch filter).

Ports:
- gclk  input  1  system clock, 25 MHz.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- scl_in  input  1  DDC SCL from source (asynchronous).
- sda_in  input  1  DDC SDA from source (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- edid_valid  input  1  EDID RAM contents complete; level.
- ram_addr  output  8  EDID RAM read address.
- ram_data  input  8  EDID RAM read data, valid 1 gclk after ram_addr.
- busy  output  1  high from accepted START with matching address until STOP or NACK-end.
- byte_sent  output  1  1-gclk pulse per data byte whose 9th (ack) clock completes.

Behaviour:
- Reset: sda_oe=0, busy=0, byte_sent=0, ram_addr=0, offset=0, state IDLE.
- Input path: 2-flop synchronizer per line, then FILT_LEN filter. Edges are detected on the filtered signals (scl_rise, scl_fall).
- START: filtered SDA falls while SCL high. STOP: SDA rises while SCL high.
- Both are recognised in every state and take priority over bit processing.
  - START (including repeated START) -> ADDR, bit count 0, sda_oe=0.
  - STOP -> IDLE, sda_oe=0, busy=0.
- Bits are sampled on scl_rise, MSB first. sda_oe changes only on the gclk after scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. Match requires addr==DEV_ADDR and edid_valid=1.
    - Match -> ADDR_ACK.
    - No match -> IGNORE (SDA released).
  - ADDR_ACK: drive 0 for the 9th clock. Release after its scl_fall.
    - R/W=0 -> WR_OFF.
    - R/W=1 -> RD_BYTE; the shift register must already hold mem[offset].
  - WR_OFF: shift 8 bits into offset, then -> OFF_ACK (ACK, then -> WR_EXTRA).
  - WR_EXTRA: further write bytes are NACKed (SDA released on 9th clock) and discarded. EDID is read-only; offset unchanged.
  - RD_BYTE: drive each bit on scl_fall. Drive sda_oe = ~bit (release for 1). After 8 bits, release SDA -> RD_ACK.
  - RD_ACK: sample master ack on the 9th scl_rise; pulse byte_sent; offset += 1 (8-bit, 0xFF wraps to 0x00).
    - ACK (0) -> RD_BYTE, next byte preloaded.
    - NACK (1) -> IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- RAM prefetch: ram_addr=offset is continuously driven.
  - Shift register loads ram_data two gclks after offset settles.
  - This is guaranteed before the next scl_fall (≥125 gclk at 100 kHz).
- Offset persists across transactions. A read without a preceding offset write continues from the last offset (standard EDID sequential read).
- edid_valid falling mid-transaction: the current transaction completes; the next address phase NACKs.
- Segment pointer address 0x30 is not answered (NACK).
- Never drive SDA during a STOP/START window. sda_oe is forced to 0 within one gclk of STOP detection.
- rst mid-transfer: immediate release of SDA; state IDLE.

Decomposition:
- Shared package: DDC state encoding constants, EDID_DEV_ADDR=7'h50, EDID_SEG_ADDR=7'h30.
- One sub-module, ddc_line_filter (synchronizer + glitch filter + edge/START/STOP detect), instantiated once for the SCL/SDA pair.
- FSM and shifter stay in edid_ddc_responder.

Test Plan:
- edid_valid=1, mem[i]=i^0x5A. Write 0xA0, 0x00, repeated START, 0xA1, read 4 bytes with ACK,ACK,ACK,NACK, STOP -> ACKs on address/offset; data 0x5A,0x5B,0x58,0x59; byte_sent pulses 4 times; busy falls at STOP.
- Offset 0xFE, read 3 bytes -> mem[0xFE], mem[0xFF], mem[0x00] (wrap).
- edid_valid=0, 0xA1 -> SDA released on 9th clock (NACK), sda_oe stays 0 thereafter.
- Address 0xA4 -> NACK, no SDA activity until STOP. A following 0xA1 read returns mem[last offset].
- Write 0xA0, 0x10, 0x77 -> ACK, ACK, NACK; subsequent read returns mem[0x10].
- 1-gclk SDA glitch while SCL high (FILT_LEN=3) -> no START/STOP detected. Assert rst mid-read -> sda_oe=0 next cycle, busy=0.
